// File: rtl/lgn_frame_sequencer_pkg.sv
// lgn_frame_sequencer_pkg
//   Shared types and elaboration-time helpers for the frame sequencer slice.
//   - seq_state_t : receive / latency-wait / transmit phases owned by the top
//   - ser_state_t : byte handshake phases owned by lgn_tx_serializer
//   - lgn_bytes_ceil, lgn_out_pad, lgn_cnt_width : size derivations
package lgn_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_WAIT = 2'd1,
    ST_XMIT = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    SER_IDLE    = 2'd0,
    SER_SEND    = 2'd2,
    SER_WAIT_TX = 2'd3
  } ser_state_t;

  // Number of whole bytes needed to carry 'bits' bits.
  function automatic int unsigned lgn_bytes_ceil(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

  // Zero bits appended below the network output to fill the last byte.
  function automatic int unsigned lgn_out_pad(input int unsigned bits);
    return lgn_bytes_ceil(bits) * 32'd8 - bits;
  endfunction

  // Counter width able to hold every value 0..max_val (at least 1 bit).
  function automatic int unsigned lgn_cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) <= 64'(max_val)) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/lgn_tx_serializer.sv
// lgn_tx_serializer
//   Snapshots the network output on i_start and sends it MSB-first, one byte
//   per uart_tx transaction, waiting for i_tx_done between bytes.
//   Ports:
//     clk, rst        system clock, synchronous active-high reset
//     i_start         1-cycle request: capture i_net_y and begin sending
//     i_net_y         network output (OUT_BITS)
//     i_tx_active     uart_tx busy; a byte is only launched while this is low
//     i_tx_done       uart_tx finished a byte (ignored unless awaiting one)
//     o_tx_byte       byte to uart_tx, held between strobes
//     o_tx_dv         1-cycle launch strobe
//     o_done          1-cycle (combinational) pulse on the tx_done of the last byte
module lgn_tx_serializer
  import lgn_frame_sequencer_pkg::*;
#(
  parameter int unsigned OUT_BITS = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [OUT_BITS-1:0] i_net_y,
  input  logic                i_tx_active,
  input  logic                i_tx_done,
  output logic [7:0]          o_tx_byte,
  output logic                o_tx_dv,
  output logic                o_done
);

  localparam int unsigned OUT_BYTES = lgn_bytes_ceil(OUT_BITS);
  localparam int unsigned OUT_W     = OUT_BYTES * 8;
  localparam int unsigned OUT_PAD   = lgn_out_pad(OUT_BITS);
  localparam int unsigned K_W       = lgn_cnt_width(OUT_BYTES - 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(OUT_BYTES - 1);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [K_W-1:0]   r_k;
  logic [K_W-1:0]   w_k_nxt;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out_shifted;
  logic [7:0]       w_sel_byte;
  logic [7:0]       r_tx_byte;
  logic             r_tx_dv;
  logic             w_load;
  logic             w_fire;

  // Byte k sits at the top after shifting left by 8*k.
  assign w_out_shifted = r_out << {r_k, 3'b000};
  assign w_sel_byte    = w_out_shifted[OUT_W-1 -: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_load      = 1'b0;
    w_fire      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_k_nxt     = '0;
          w_state_nxt = SER_SEND;
        end
      end
      SER_SEND: begin
        if (!i_tx_active) begin
          w_fire      = 1'b1;
          w_state_nxt = SER_WAIT_TX;
        end
      end
      SER_WAIT_TX: begin
        if (i_tx_done) begin
          if (r_k == K_LAST) begin
            o_done      = 1'b1;
            w_state_nxt = SER_IDLE;
          end else begin
            w_k_nxt     = r_k + 1'b1;
            w_state_nxt = SER_SEND;
          end
        end
      end
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= SER_IDLE;
      r_k       <= '0;
      r_out     <= '0;
      r_tx_byte <= '0;
      r_tx_dv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_tx_dv <= w_fire;
      if (w_fire) r_tx_byte <= w_sel_byte;
      // Left-align the output so the pad bits land at the bottom of the last byte.
      if (w_load) r_out <= OUT_W'(i_net_y) << OUT_PAD;
    end
  end

  assign o_tx_byte = r_tx_byte;
  assign o_tx_dv   = r_tx_dv;

endmodule

// File: rtl/lgn_frame_sequencer.sv
// lgn_frame_sequencer
//   Runs one logic_network inference per UART frame: collects IN_BITS/8 bytes
//   into net_x, waits NET_LATENCY cycles, snapshots net_y and hands it to
//   lgn_tx_serializer for byte-wise transmission.
//   Ports:
//     clk, rst     system clock, synchronous active-high reset
//     rx_byte/rx_dv  received byte and its 1-cycle strobe
//     net_x        network input; byte 0 in the top 8 bits
//     net_y        network output
//     tx_byte/tx_dv  byte and launch strobe to uart_tx
//     tx_active    uart_tx busy
//     tx_done      uart_tx byte complete strobe
//     busy         high whenever not receiving
//     frame_err    1-cycle pulse when a partial frame is dropped on timeout
//     frame_count  completed frames, wraps
module lgn_frame_sequencer
  import lgn_frame_sequencer_pkg::*;
#(
  parameter int unsigned IN_BITS     = 400,
  parameter int unsigned OUT_BITS    = 50,
  parameter int unsigned NET_LATENCY = 1,
  parameter int unsigned RX_TIMEOUT  = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_dv,
  output logic [IN_BITS-1:0]  net_x,
  input  logic [OUT_BITS-1:0] net_y,
  output logic [7:0]          tx_byte,
  output logic                tx_dv,
  input  logic                tx_active,
  input  logic                tx_done,
  output logic                busy,
  output logic                frame_err,
  output logic [15:0]         frame_count
);

  localparam int unsigned IN_BYTES = IN_BITS / 8;
  localparam int unsigned IDX_W    = lgn_cnt_width(IN_BYTES - 1);
  localparam int unsigned LAT_W    = lgn_cnt_width(NET_LATENCY);
  localparam int unsigned IDLE_W   = lgn_cnt_width(RX_TIMEOUT);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(IN_BYTES - 1);
  localparam logic [LAT_W-1:0]  LAT_TGT   = LAT_W'(NET_LATENCY);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(RX_TIMEOUT - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [LAT_W-1:0]    r_lat;
  logic [LAT_W-1:0]    w_lat_nxt;
  logic [IDLE_W-1:0]   r_idle;
  logic [IDLE_W-1:0]   w_idle_nxt;
  logic [IN_BITS-1:0]  r_net_x;
  logic                r_frame_err;
  logic [15:0]         r_frame_count;
  logic                w_store;
  logic                w_timeout;
  logic                w_start;
  logic                w_frame_inc;
  logic                w_ser_done;

  // SEND/WAIT_TX live in the serializer; ST_XMIT covers both here and exits
  // on the serializer's last-byte tx_done, so state timing is unchanged.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lat_nxt   = r_lat;
    w_idle_nxt  = r_idle;
    w_store     = 1'b0;
    w_timeout   = 1'b0;
    w_start     = 1'b0;
    w_frame_inc = 1'b0;
    case (r_state)
      ST_RECV: begin
        if (rx_dv) begin
          // A byte in the expiry cycle wins over the timeout.
          w_store    = 1'b1;
          w_idle_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_lat_nxt   = '0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else if (r_idx != '0) begin
          if (r_idle == IDLE_LAST) begin
            w_timeout  = 1'b1;
            w_idx_nxt  = '0;
            w_idle_nxt = '0;
          end else begin
            w_idle_nxt = r_idle + 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (r_lat == LAT_TGT) begin
          w_start     = 1'b1;
          w_state_nxt = ST_XMIT;
        end else begin
          w_lat_nxt = r_lat + 1'b1;
        end
      end
      ST_XMIT: begin
        if (w_ser_done) begin
          w_frame_inc = 1'b1;
          w_state_nxt = ST_RECV;
        end
      end
      default: w_state_nxt = ST_RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RECV;
      r_idx         <= '0;
      r_lat         <= '0;
      r_idle        <= '0;
      r_frame_err   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_lat       <= w_lat_nxt;
      r_idle      <= w_idle_nxt;
      r_frame_err <= w_timeout;
      if (w_frame_inc) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Only written in RECV, so net_x is frozen from WAIT until the frame is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_net_x <= '0;
    end else if (w_store) begin
      for (int unsigned b = 0; b < IN_BYTES; b++) begin
        if (r_idx == IDX_W'(b)) r_net_x[IN_BITS-1-8*b -: 8] <= rx_byte;
      end
    end
  end

  lgn_tx_serializer #(
    .OUT_BITS(OUT_BITS)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_start),
    .i_net_y    (net_y),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .o_tx_byte  (tx_byte),
    .o_tx_dv    (tx_dv),
    .o_done     (w_ser_done)
  );

  assign net_x       = r_net_x;
  assign busy        = (r_state != ST_RECV);
  assign frame_err   = r_frame_err;
  assign frame_count = r_frame_count;

endmodule
